fetch_stage: RTL

// - Fetch stage directly upstream of icache_subsystem.
// - Holds the PC and presents two sequential read addresses (PC, PC+4) per cycle.
// - Extracts 32-bit instructions from the returned 64-bit cache blocks and pushes hits, in order, into an instruction buffer FIFO.
// - The buffer is drained by dispatch. A redirect flushes the buffer and reloads the PC.

---
 rtl/fetch_if.sv | 19 +
 rtl/fetch_stage.sv | 71 +++++++
 2 files changed

// File: rtl/fetch_if.sv
// fetch_if: fetch-stage bus bundling cache reads, redirect, dispatch drain and buffer outputs
interface fetch_if #(parameter int IBUF_DEPTH = 8);
  logic                               redirect_valid;
  logic [31:0]                        redirect_pc;
  logic [1:0][32:0]                   read_addrs;
  logic [1:0][64:0]                   cache_outs;
  logic [1:0]                         deq_count;
  logic [1:0][64:0]                   inst_out;
  logic [$clog2(IBUF_DEPTH+1)-1:0]    ibuf_count;
  logic [31:0]                        miss_stall_cnt;
  modport master (
    input  redirect_valid, redirect_pc, cache_outs, deq_count,
    output read_addrs, inst_out, ibuf_count, miss_stall_cnt
  );
  modport slave (
    output redirect_valid, redirect_pc, cache_outs, deq_count,
    input  read_addrs, inst_out, ibuf_count, miss_stall_cnt
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: dual-address PC fetch feeding an in-order instruction buffer drained by dispatch
module fetch_stage #(
  parameter int          IBUF_DEPTH = 8,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input logic      clock,
  input logic      reset,
  fetch_if.master  bus
);
  localparam int PW = $clog2(IBUF_DEPTH);
  localparam int CW = $clog2(IBUF_DEPTH + 1);
  logic [31:0]   pc, pc4, inst0, inst1, stall_cnt;
  logic [PW-1:0] head, tail, head1;
  logic [CW-1:0] count, free, deq_req, deq_eff, enq;
  logic          issue, hit0, hit1;
  logic [31:0]   ib_inst [IBUF_DEPTH];
  logic [31:0]   ib_pc   [IBUF_DEPTH];
  always_comb begin
    pc4     = pc + 32'd4;
    free    = CW'(IBUF_DEPTH) - count;
    issue   = ~reset & ~bus.redirect_valid & (free >= CW'(2));
    // slot 1 only counts when slot 0 hit, so the buffer never sees a gap
    hit0    = issue & bus.cache_outs[0][64];
    hit1    = hit0 & bus.cache_outs[1][64];
    inst0   = pc[2]  ? bus.cache_outs[0][63:32] : bus.cache_outs[0][31:0];
    inst1   = pc4[2] ? bus.cache_outs[1][63:32] : bus.cache_outs[1][31:0];
    enq     = CW'(hit0) + CW'(hit1);
    deq_req = CW'(bus.deq_count);
    deq_eff = (deq_req > count) ? count : deq_req;
    head1   = head + PW'(1);
    bus.read_addrs[0]  = {issue, pc};
    bus.read_addrs[1]  = {issue, pc4};
    bus.inst_out[0]    = {count != '0, ib_inst[head], ib_pc[head]};
    bus.inst_out[1]    = {count > CW'(1), ib_inst[head1], ib_pc[head1]};
    bus.ibuf_count     = count;
    bus.miss_stall_cnt = stall_cnt;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      pc        <= RESET_PC;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      stall_cnt <= '0;
    end else begin
      if (bus.redirect_valid) begin
        pc    <= {bus.redirect_pc[31:2], 2'b00};
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        pc    <= hit1 ? pc + 32'd8 : hit0 ? pc4 : pc;
        head  <= head + PW'(deq_eff);
        tail  <= tail + PW'(enq);
        count <= count + enq - deq_eff;
      end
      if (issue & ~bus.cache_outs[0][64] & ~&stall_cnt) stall_cnt <= stall_cnt + 32'd1;
    end
  end
  // storage needs no reset: validity is tracked solely by count
  always_ff @(posedge clock) begin
    if (hit0) begin
      ib_inst[tail] <= inst0;
      ib_pc[tail]   <= pc;
    end
    if (hit1) begin
      ib_inst[tail + PW'(1)] <= inst1;
      ib_pc[tail + PW'(1)]   <= pc4;
    end
  end
endmodule
